reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 14 +
 rtl/timestamp_counter.sv | 30 +++
 rtl/reset_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and default parameters for the reset sequencer slice.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    CFG_RST  = 2'd0,
    CORE_RST = 2'd1,
    RUN      = 2'd2
  } seq_state_t;

  localparam int TS_WIDTH_DEF   = 32;
  localparam int CFG_DELAY_DEF  = 4;
  localparam int CORE_DELAY_DEF = 8;

endpackage

// File: rtl/timestamp_counter.sv
// Free-running timestamp with a one-cycle wrap pulse; clear has priority over enable.
module timestamp_counter #(
  parameter int TS_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                enable,
  output logic [TS_WIDTH-1:0] timestamp,
  output logic                rollover
);

  localparam logic [TS_WIDTH-1:0] TS_ONE = TS_WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timestamp <= '0;
      rollover  <= 1'b0;
    end else if (clear) begin
      timestamp <= '0;
      rollover  <= 1'b0;
    end else if (enable) begin
      timestamp <= timestamp + TS_ONE;
      rollover  <= &timestamp;
    end else begin
      rollover  <= 1'b0;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged release of config and core resets, followed by a timestamp that
// restarts from zero on every entry into RUN.
import reset_seq_pkg::*;

module reset_sequencer #(
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int CFG_DELAY  = CFG_DELAY_DEF,
  parameter int CORE_DELAY = CORE_DELAY_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                reset_n_sync,
  input  logic                reset_n_config_sync,
  output logic                reset_n_config_out,
  output logic                reset_n_core,
  output logic                sync_pulse,
  output logic [TS_WIDTH-1:0] timestamp,
  output logic                ts_rollover,
  output logic [1:0]          seq_state,
  output logic                reset_busy
);

  localparam logic [7:0] CFG_LAST  = 8'(CFG_DELAY - 1);
  localparam logic [7:0] CORE_LAST = 8'(CORE_DELAY - 1);

  logic       r_sync;
  logic       r_cfg;
  seq_state_t state_reg;
  seq_state_t state_next;
  logic [7:0] hold_cnt_reg;
  logic [7:0] hold_cnt_next;
  logic       run_stay;

  // Counter falls back to zero on any transition or when the stay condition drops.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = '0;
    case (state_reg)
      CFG_RST: begin
        if (r_cfg && r_sync) begin
          if (hold_cnt_reg == CFG_LAST) state_next = CORE_RST;
          else hold_cnt_next = hold_cnt_reg + 8'd1;
        end
      end
      CORE_RST: begin
        if (!r_cfg) begin
          state_next = CFG_RST;
        end else if (r_sync) begin
          if (hold_cnt_reg == CORE_LAST) state_next = RUN;
          else hold_cnt_next = hold_cnt_reg + 8'd1;
        end
      end
      RUN: begin
        if (!r_cfg) state_next = CFG_RST;
        else if (!r_sync) state_next = CORE_RST;
      end
      default: state_next = CFG_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync             <= 1'b0;
      r_cfg              <= 1'b0;
      state_reg          <= CFG_RST;
      hold_cnt_reg       <= '0;
      reset_n_config_out <= 1'b0;
      reset_n_core       <= 1'b0;
      reset_busy         <= 1'b1;
      sync_pulse         <= 1'b0;
    end else begin
      r_sync             <= reset_n_sync;
      r_cfg              <= reset_n_config_sync;
      state_reg          <= state_next;
      hold_cnt_reg       <= hold_cnt_next;
      reset_n_config_out <= (state_next != CFG_RST);
      reset_n_core       <= (state_next == RUN);
      reset_busy         <= (state_next != RUN);
      sync_pulse         <= (state_next == RUN) && (state_reg != RUN);
    end
  end

  assign seq_state = state_reg;

  // Counting only happens on edges that stay in RUN, so the entry edge loads zero.
  assign run_stay = (state_reg == RUN) && (state_next == RUN);

  timestamp_counter #(
    .TS_WIDTH(TS_WIDTH)
  ) u_timestamp_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (!run_stay),
    .enable   (run_stay),
    .timestamp(timestamp),
    .rollover (ts_rollover)
  );

endmodule
